// File: rtl/wb_mem_timer.sv
// wb_mem_timer: Wishbone classic responder with byte-lane RAM,
// programmable wait states and a 64-bit machine timer driving irq.
module wb_mem_timer #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned WAIT       = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] bus__adr,
   input  logic        bus__cyc,
   input  logic        bus__stb,
   input  logic        bus__we,
   input  logic [3:0]  bus__sel,
   input  logic [31:0] bus__dat_w,
   output logic [31:0] bus__dat_r,
   output logic        bus__ack,
   output logic        irq
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = 2;

   // Reject wait-state counts the counter and bus contract cannot honour
   generate
      if (WAIT == 0 || WAIT > 3) begin : g_bad_wait
         $error("wb_mem_timer: WAIT must be in 1..3");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [29:0]            adr_q, adr_d;
   logic                   we_q, we_d;
   logic [3:0]             sel_q, sel_d;
   logic [31:0]            dat_q, dat_d;
   logic [31:0]            dat_r_q, dat_r_d;
   logic                   irq_q, irq_d;
   logic [63:0]            mtime_q, mtime_d;
   logic [63:0]            mtcmp_q, mtcmp_d;
   logic                   commit_c;
   logic                   ram_wr_c;
   logic                   tmr_wr_c;
   logic [31:0]            rd_c;
   logic [DEPTH_LOG2-1:0]  ram_idx;
   logic                   unused_adr;
   logic [31:0]            mem_q [DEPTH];

   // Replace only the byte lanes enabled in sel_v
   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] wr_v,
                                              input logic [3:0]  sel_v);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (sel_v[i]) r[8*i +: 8] = wr_v[8*i +: 8];
      end
      return r;
   endfunction

   // Request FSM; *_d carries the request in force on the commit edge
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      adr_d    = adr_q;
      we_d     = we_q;
      sel_d    = sel_q;
      dat_d    = dat_q;
      commit_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus__cyc && bus__stb) begin
               adr_d = bus__adr;
               we_d  = bus__we;
               sel_d = bus__sel;
               dat_d = bus__dat_w;
               cnt_d = CNT_W'(WAIT - 1);
               if (WAIT == 1) begin
                  state_d  = ST_ACK;
                  commit_c = 1'b1;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (!bus__cyc) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_ACK;
               commit_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign ram_idx    = adr_d[DEPTH_LOG2-1:0];
   assign ram_wr_c   = commit_c && we_d && !adr_d[29] && !rst;
   assign tmr_wr_c   = commit_c && we_d && adr_d[29];
   assign unused_adr = ^adr_d;

   // Read mux; mtime is sampled before this edge's increment
   always_comb begin
      rd_c = 32'h0;
      if (adr_d[29]) begin
         case (adr_d[1:0])
            2'd0:    rd_c = mtime_q[31:0];
            2'd1:    rd_c = mtime_q[63:32];
            2'd2:    rd_c = mtcmp_q[31:0];
            default: rd_c = mtcmp_q[63:32];
         endcase
      end else begin
         rd_c = mem_q[ram_idx];
      end
      dat_r_d = (commit_c && !we_d) ? rd_c : 32'h0;
   end

   // Timer next state: free-running mtime unless an mtime half is written
   always_comb begin
      mtime_d = mtime_q + 64'd1;
      mtcmp_d = mtcmp_q;
      irq_d   = (mtime_q >= mtcmp_q);
      if (tmr_wr_c) begin
         case (adr_d[1:0])
            2'd0:    mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], dat_d, sel_d)};
            2'd1:    mtime_d = {lane_merge(mtime_q[63:32], dat_d, sel_d), mtime_q[31:0]};
            2'd2:    mtcmp_d = {mtcmp_q[63:32], lane_merge(mtcmp_q[31:0], dat_d, sel_d)};
            default: mtcmp_d = {lane_merge(mtcmp_q[63:32], dat_d, sel_d), mtcmp_q[31:0]};
         endcase
      end
   end

   // State, latched request, read data and timer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         dat_q   <= '0;
         dat_r_q <= '0;
         irq_q   <= 1'b0;
         mtime_q <= '0;
         mtcmp_q <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         dat_r_q <= dat_r_d;
         irq_q   <= irq_d;
         mtime_q <= mtime_d;
         mtcmp_q <= mtcmp_d;
      end
   end

   // RAM array is not reset; writes land on the edge entering ACK
   always_ff @(posedge clk) begin
      if (ram_wr_c) mem_q[ram_idx] <= lane_merge(mem_q[ram_idx], dat_d, sel_d);
   end

   assign bus__ack   = (state_q == ST_ACK);
   assign bus__dat_r = dat_r_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_wb_mem_timer.sv
// Bench for wb_mem_timer: three instances (WAIT=1,2,3) checked against
// an arithmetic model of RAM contents and the timer.
module tb_wb_mem_timer;

   logic        clk;
   logic        rst;
   logic [29:0] adr [3];
   logic        cyc [3];
   logic        stb [3];
   logic        we  [3];
   logic [3:0]  sel [3];
   logic [31:0] dw  [3];
   logic [31:0] dr  [3];
   logic        ack [3];
   logic        irq [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wb_mem_timer #(.DEPTH_LOG2(10), .WAIT(g + 1)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .bus__adr   (adr[g]),
         .bus__cyc   (cyc[g]),
         .bus__stb   (stb[g]),
         .bus__we    (we[g]),
         .bus__sel   (sel[g]),
         .bus__dat_w (dw[g]),
         .bus__dat_r (dr[g]),
         .bus__ack   (ack[g]),
         .irq        (irq[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; mtime equals this count absent writes
   int cyc_n;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc_n <= 0;
      else     cyc_n <= cyc_n + 1;
   end

   // Reference model
   logic [31:0] mref [3][1024];
   bit          mval [3][1024];
   logic [63:0] mt_base [3];
   int          mt_t0   [3];
   logic [63:0] cmp_m   [3];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
   endtask

   function automatic logic [63:0] mt_at(input int k, input int c);
      return mt_base[k] + 64'(c - mt_t0[k]);
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~m) | (d & m);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mt_base[k] = 64'd0;
         mt_t0[k]   = 0;
         cmp_m[k]   = 64'hFFFF_FFFF_FFFF_FFFF;
      end
   endtask

   task automatic check_irq(input int k);
      check("irq_level", irq[k], (mt_at(k, cyc_n - 1) >= cmp_m[k]) ? 64'd1 : 64'd0);
   endtask

   // One bus transaction; e is the edge count at which the DUT enters ACK
   task automatic txn(input int k, input logic w, input logic [29:0] a,
                      input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
      int lat;
      int e;
      bit got;
      logic [63:0] v;
      logic [31:0] exp;
      bit known;
      @(posedge clk); #1;
      adr[k] = a; we[k] = w; sel[k] = s; dw[k] = d; cyc[k] = 1'b1; stb[k] = 1'b1;
      @(negedge clk);
      check("ack_first_cycle", ack[k], 0);
      lat = 0; got = 0;
      while (!got && lat < 8) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (ack[k]) got = 1;
      end
      check("ack_latency", 64'(lat), 64'(k + 1));
      rd = dr[k];
      e  = cyc_n;
      if (got && w) begin
         if (!a[29]) begin
            if (s == 4'hF || mval[k][a[9:0]]) mval[k][a[9:0]] = 1;
            mref[k][a[9:0]] = lanes(mref[k][a[9:0]], d, s);
         end else begin
            v = mt_at(k, e - 1);
            case (a[1:0])
               2'd0: begin v[31:0]  = lanes(v[31:0],  d, s); mt_base[k] = v; mt_t0[k] = e; end
               2'd1: begin v[63:32] = lanes(v[63:32], d, s); mt_base[k] = v; mt_t0[k] = e; end
               2'd2: cmp_m[k][31:0]  = lanes(cmp_m[k][31:0],  d, s);
               default: cmp_m[k][63:32] = lanes(cmp_m[k][63:32], d, s);
            endcase
         end
      end else if (got) begin
         known = 1;
         exp   = 32'h0;
         if (!a[29]) begin
            known = mval[k][a[9:0]];
            exp   = mref[k][a[9:0]];
         end else begin
            v = mt_at(k, e - 1);
            case (a[1:0])
               2'd0:    exp = v[31:0];
               2'd1:    exp = v[63:32];
               2'd2:    exp = cmp_m[k][31:0];
               default: exp = cmp_m[k][63:32];
            endcase
         end
         if (known) check("read_data", rd, exp);
      end
      @(posedge clk); #1;
      cyc[k] = 1'b0; stb[k] = 1'b0;
      @(negedge clk);
      check("ack_single", ack[k], 0);
      check("dat_r_idle_zero", dr[k], 0);
   endtask

   localparam logic [29:0] T_MLO = 30'h2000_0000;
   localparam logic [29:0] T_MHI = 30'h2000_0001;
   localparam logic [29:0] T_CLO = 30'h2000_0002;
   localparam logic [29:0] T_CHI = 30'h2000_0003;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [29:0] a;
      bit saw;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         adr[k] = '0; cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = '0; dw[k] = '0;
         for (int i = 0; i < 1024; i++) begin mval[k][i] = 0; mref[k][i] = '0; end
      end
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("reset_ack", ack[k], 0);
         check("reset_dat_r", dr[k], 0);
         check("reset_irq", irq[k], 0);
      end
      @(posedge clk); #1 rst = 1'b0;

      // Compare value {0,100} on the WAIT=1 instance, early enough that mtime < 100
      txn(0, 1, T_CLO, 4'hF, 32'd100, rd);
      txn(0, 1, T_CHI, 4'hF, 32'd0, rd);
      check_irq(0);

      // Basic write/read and byte lanes
      txn(0, 1, 30'd5, 4'hF, 32'hDEAD_BEEF, rd);
      txn(0, 0, 30'd5, 4'hF, 32'h0, rd);
      check("read_adr5", rd, 32'hDEAD_BEEF);
      txn(0, 1, 30'd7, 4'hF, 32'h1122_3344, rd);
      txn(0, 1, 30'd7, 4'b0101, 32'hAABB_CCDD, rd);
      txn(0, 0, 30'd7, 4'h0, 32'h0, rd);
      check("byte_lanes", rd, 32'h11BB_33DD);

      // cyc without stb must be ignored
      @(posedge clk); #1;
      adr[0] = 30'd5; we[0] = 1; sel[0] = 4'hF; dw[0] = 32'h0; cyc[0] = 1; stb[0] = 0;
      saw = 0;
      repeat (4) begin @(negedge clk); if (ack[0]) saw = 1; end
      check("stb_low_no_ack", saw, 0);
      #1 cyc[0] = 0;
      txn(0, 0, 30'd5, 4'hF, 32'h0, rd);

      // irq rises when mtime reaches 100
      while (cyc_n < 106) begin @(negedge clk); check_irq(0); end
      check("irq_high", irq[0], 1);
      txn(0, 1, T_CHI, 4'hF, 32'd1, rd);
      check_irq(0);
      check("irq_fell", irq[0], 0);

      // mtime low-half write and carry into the high half
      txn(0, 1, T_MLO, 4'hF, 32'hFFFF_FFFE, rd);
      repeat (4) @(posedge clk);
      txn(0, 0, T_MHI, 4'hF, 32'h0, rd);
      check("mtime_carry", rd, 32'h1);
      txn(0, 0, T_MLO, 4'hF, 32'h0, rd);
      check_irq(0);

      // Randomized traffic with aliased RAM addresses and timer reads
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) txn(k, 1, 30'(i), 4'hF, $urandom, rd);
         for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 7)
               a = {1'b0, 19'($urandom), 10'($urandom_range(0, 15))};
            else
               a = {1'b1, 27'($urandom), 2'($urandom_range(0, 3))};
            if (!a[29] && $urandom_range(0, 1) == 1)
               txn(k, 1, a, 4'($urandom), $urandom, rd);
            else
               txn(k, 0, a, 4'($urandom), 32'h0, rd);
            repeat ($urandom_range(0, 2)) @(posedge clk);
         end
      end

      // Abort on WAIT=3: drop cyc while BUSY, no ack and no write
      txn(2, 1, 30'd9, 4'hF, 32'h1234_5678, rd);
      @(posedge clk); #1;
      adr[2] = 30'd9; we[2] = 1; sel[2] = 4'hF; dw[2] = 32'h0BAD_0BAD; cyc[2] = 1; stb[2] = 1;
      @(posedge clk); #1;
      cyc[2] = 0; stb[2] = 0;
      saw = 0;
      repeat (6) begin @(negedge clk); if (ack[2]) saw = 1; end
      check("abort_no_ack", saw, 0);
      txn(2, 0, 30'd9, 4'hF, 32'h0, rd);
      check("abort_no_write", rd, 32'h1234_5678);

      // Reset in the middle of a WAIT=2 write, with irq held high
      txn(1, 1, 30'd11, 4'hF, 32'hCAFE_F00D, rd);
      txn(1, 1, T_CLO, 4'hF, 32'd0, rd);
      txn(1, 1, T_CHI, 4'hF, 32'd0, rd);
      check("irq_pre_reset", irq[1], 1);
      @(posedge clk); #1;
      adr[1] = 30'd11; we[1] = 1; sel[1] = 4'hF; dw[1] = 32'h0; cyc[1] = 1; stb[1] = 1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_ack", ack[1], 0);
      check("rst_dat_r", dr[1], 0);
      check("rst_irq", irq[1], 0);
      cyc[1] = 0; stb[1] = 0;
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      txn(1, 0, 30'd11, 4'hF, 32'h0, rd);
      check("rst_no_write", rd, 32'hCAFE_F00D);
      txn(1, 0, T_MLO, 4'hF, 32'h0, rd);
      txn(1, 0, T_CHI, 4'hF, 32'h0, rd);
      check_irq(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_mem_timer.md
# wb_mem_timer

Wishbone classic responder that sits at the far end of the core's `bus__*` initiator port. It provides word-addressed RAM with byte lanes and a configurable number of wait states. It also provides a 64-bit machine timer whose compare match drives the core's `irq` input. It serves as the standard memory/peripheral model for simulation benches and small SoC builds, and it honours the bus contract the core is verified against: never ack in the cycle a request first appears, and ack within 4 cycles.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT`, 1: cycles from first sampling `cyc&stb` to asserting `ack`. Legal range 1..3; elaboration fails outside it.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bus__adr`  in  30  word address.
- `bus__cyc`  in  1  cycle valid.
- `bus__stb`  in  1  strobe.
- `bus__we`  in  1  1 = write.
- `bus__sel`  in  4  byte-lane enables; bit i covers `dat_w[8i+7:8i]`.
- `bus__dat_w`  in  32  write data.
- `bus__dat_r`  out  32  read data; valid only while `ack`=1, 0 otherwise.
- `bus__ack`  out  1  single-cycle acknowledge.
- `irq`  out  1  timer interrupt, level.

## Operation
Address decode:
- `adr[29]`=0 selects RAM, indexed by `adr[DEPTH_LOG2-1:0]`. Upper bits alias.
- `adr[29]`=1 selects the timer, with registers chosen by `adr[1:0]`:
  - 0: `mtime[31:0]`
  - 1: `mtime[63:32]`
  - 2: `mtimecmp[31:0]`
  - 3: `mtimecmp[63:32]`
  - `adr[28:2]` is ignored.

FSM states: IDLE, BUSY, ACK.
- IDLE: on `cyc&stb`, latch adr/we/sel/dat_w and load the wait counter with WAIT-1.
  - If WAIT=1, go to ACK.
  - Otherwise go to BUSY.
- BUSY: the counter decrements each cycle; go to ACK when it reaches 1.
  - If `cyc` is low in any BUSY cycle, abort: return to IDLE with no ack and no write.
- ACK: `ack`=1 for exactly one cycle, then IDLE.
  - `cyc&stb` in the ACK cycle is not a new request. The next request is sampled in IDLE at the earliest, so acks are never back-to-back.

Writes:
- Committed on the edge that enters ACK, using latched values.
- Only lanes with `sel[i]`=1 are modified. `sel`=0 is legal and writes nothing.
- Writes also apply to timer registers, per lane.

Reads:
- `dat_r` is registered on the edge entering ACK, from latched adr, and returns all 32 bits regardless of `sel`.
- A read of `mtime` returns the value before that edge's increment.
- `dat_r` returns to 0 on the edge leaving ACK.

Timer:
- `mtime` increments by 1 every cycle and wraps 2^64-1 to 0.
- A write to an `mtime` half replaces that half's next value (lanes per `sel`); the increment is suppressed that cycle for the whole 64-bit register.
- `irq` is registered as `irq <= (mtime >= mtimecmp)` using pre-edge values, unsigned 64-bit compare.
- `irq` stays high until software raises `mtimecmp` above `mtime` or writes `mtime` below it.

Reset values (asynchronous, immediate):
- FSM IDLE, `ack`=0, `dat_r`=0, `irq`=0.
- `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF.
- RAM is not reset; its contents are undefined.

## Timing
- Request first sampled at edge N: `ack` is high in cycle N+WAIT. With WAIT=1, `ack` is high the cycle after the request.
- Minimum spacing between acks: WAIT+1 cycles.
- Write is visible to a read request issued after the ack cycle.
- Timer write at edge E: the compare result reflects it at edge E+1, so `irq` changes by cycle E+2.
- Reset asserted mid-transaction: `ack` drops immediately, no write is committed, and the FSM restarts in IDLE on release.
- `stb` low with `cyc` high in IDLE: no action.
- `cyc` low in ACK: ack still completes (initiator-side abort is handled by the initiator).

## Test plan
- WAIT=1: write 32'hDEADBEEF to adr 5 with sel=4'hF; read adr 5 → `ack` exactly one cycle after request, `dat_r`=32'hDEADBEEF, `ack` never in the request's first cycle.
- Byte lanes: RAM[7]=32'h11223344, then write 32'hAABBCCDD with sel=4'b0101 → read returns 32'h11BB33DD.
- Abort: WAIT=3, write request to adr 9, drop `cyc` after 1 cycle → no ack, RAM[9] unchanged; next request is acked normally.
- Timer irq: write `mtimecmp`={32'h0, 32'd100} after reset → `irq` rises once `mtime` reaches 100 (one-cycle register lag); write `mtimecmp_hi`=1 → `irq` falls within 2 cycles.
- `mtime` write: write `mtime_lo`=32'hFFFF_FFFE, then read `mtime_hi` after 3+ cycles → 32'h1 (carry across halves); read of `mtime_lo` returns the pre-increment value.
- Reset mid-BUSY with WAIT=2 → `ack`, `dat_r` and `irq` are 0 immediately, `mtime`=0, and no write is committed.
